memory_ram_ws: RTL and testbench

//  Parametrised successor of the core's data RAM: byte-addressed, byte/half/word store

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/ram_lane_align.sv | 45 ++++
 rtl/memory_ram_ws.sv | 161 ++++++++++++++++
 tb/tb_memory_ram_ws.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the wait-state data RAM: access sizes, FSM states and
// wait counter width.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/ram_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication,
// load lane select with sign/zero extension, and misalignment detection.
module ram_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    be       = '0;
    wr_word  = st_data;
    ld_data  = rd_word;
    misalign = 1'b0;
    shifted  = rd_word >> {lane, 3'b000};
    case (size)
      SIZE_B: begin
        be      = 4'b0001 << lane;
        wr_word = {4{st_data[7:0]}};
        ld_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{st_data[15:0]}};
        ld_data  = {{16{~uns & shifted[15]}}, shifted[15:0]};
        misalign = lane[0];
      end
      SIZE_W: begin
        be       = '1;
        misalign = (lane != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_ram_ws.sv
// Byte-addressed data RAM with byte/half/word lanes, load extension and
// programmable read/write wait states behind a REQ/ACK handshake.
module memory_ram_ws
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned WAIT_RD = 0,
  parameter int unsigned WAIT_WR = 0,
  parameter              INIT_FILE = ""
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRAM_CE,
  input  logic              iRAM_REQ,
  input  logic              iRAM_WR,
  input  logic [1:0]        iRAM_SIZE,
  input  logic              iRAM_UNS,
  input  logic [ADDR_W-1:0] iRAM_ADDR,
  input  logic [31:0]       iRAM_DATA,
  output logic [31:0]       oRAM_DATA,
  output logic              oRAM_ACK,
  output logic              oRAM_ERR,
  output logic              oRAM_BUSY
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(WAIT_RD);
  localparam logic [CNT_W-1:0] CNT_WR = CNT_W'(WAIT_WR);

  if (WAIT_RD > 15 || WAIT_WR > 15) begin : g_bad_wait
    $error("memory_ram_ws: WAIT_RD/WAIT_WR must be 0..15");
  end
  if ((64'd1 << (ADDR_W - 2)) < 64'(DEPTH)) begin : g_bad_addr
    $error("memory_ram_ws: ADDR_W too narrow for DEPTH");
  end

  logic [31:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        data_q, data_d;

  logic               idle;
  logic [1:0]         sel_size;
  logic               sel_uns;
  logic [ADDR_W-1:0]  sel_addr;
  logic               in_range;
  logic [3:0]         be;
  logic [31:0]        wr_word;
  logic [31:0]        ld_data;
  logic               misalign;
  logic               commit;

  // Error decode sees the live request in IDLE; commit later uses latched fields.
  assign idle     = (state_q == S_IDLE);
  assign sel_size = idle ? iRAM_SIZE : size_q;
  assign sel_uns  = idle ? iRAM_UNS  : uns_q;
  assign sel_addr = idle ? iRAM_ADDR : addr_q;
  assign in_range = 32'(sel_addr[ADDR_W-1:2]) < DEPTH;

  ram_lane_align u_align (
    .size     (sel_size),
    .uns      (sel_uns),
    .lane     (sel_addr[1:0]),
    .st_data  (wdata_q),
    .rd_word  (mem[sel_addr[2 +: AW]]),
    .be       (be),
    .wr_word  (wr_word),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  // A good access always spends one WAIT cycle with cnt==0 before RESP, giving
  // ACK in the cycle after edge N+1+WAIT_x; errors skip WAIT entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    data_d  = data_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iRAM_CE && iRAM_REQ) begin
          wr_d    = iRAM_WR;
          size_d  = iRAM_SIZE;
          uns_d   = iRAM_UNS;
          addr_d  = iRAM_ADDR;
          wdata_d = iRAM_DATA;
          err_d   = misalign || !in_range;
          if (misalign || !in_range) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = iRAM_WR ? CNT_WR : CNT_RD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
          if (!wr_q) data_d = ld_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (commit && wr_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[2 +: AW]][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign oRAM_DATA = data_q;
  assign oRAM_ACK  = (state_q == S_RESP);
  assign oRAM_ERR  = (state_q == S_RESP) && err_q;
  assign oRAM_BUSY = !idle;

endmodule

// File: tb/tb_memory_ram_ws.sv
// Directed bench for memory_ram_ws: three instances with different wait-state
// settings share one clock; expected values are hand-computed constants.
module tb_memory_ram_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        ce   [3];
  logic        req  [3];
  logic        wr   [3];
  logic        uns  [3];
  logic [1:0]  sz   [3];
  logic [9:0]  addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        ack  [3];
  logic        er   [3];
  logic        busy [3];
  logic [31:0] last_q [3];

  int checks = 0;
  int errors = 0;

  memory_ram_ws #(.DEPTH(128), .ADDR_W(10), .WAIT_RD(0), .WAIT_WR(0)) u_dut0 (
    .iCLK(clk), .iRST(rst[0]), .iRAM_CE(ce[0]), .iRAM_REQ(req[0]), .iRAM_WR(wr[0]),
    .iRAM_SIZE(sz[0]), .iRAM_UNS(uns[0]), .iRAM_ADDR(addr[0]), .iRAM_DATA(wd[0]),
    .oRAM_DATA(rd[0]), .oRAM_ACK(ack[0]), .oRAM_ERR(er[0]), .oRAM_BUSY(busy[0]));

  memory_ram_ws #(.DEPTH(256), .ADDR_W(10), .WAIT_RD(3), .WAIT_WR(1)) u_dut1 (
    .iCLK(clk), .iRST(rst[1]), .iRAM_CE(ce[1]), .iRAM_REQ(req[1]), .iRAM_WR(wr[1]),
    .iRAM_SIZE(sz[1]), .iRAM_UNS(uns[1]), .iRAM_ADDR(addr[1]), .iRAM_DATA(wd[1]),
    .oRAM_DATA(rd[1]), .oRAM_ACK(ack[1]), .oRAM_ERR(er[1]), .oRAM_BUSY(busy[1]));

  memory_ram_ws #(.DEPTH(256), .ADDR_W(10), .WAIT_RD(0), .WAIT_WR(4)) u_dut2 (
    .iCLK(clk), .iRST(rst[2]), .iRAM_CE(ce[2]), .iRAM_REQ(req[2]), .iRAM_WR(wr[2]),
    .iRAM_SIZE(sz[2]), .iRAM_UNS(uns[2]), .iRAM_ADDR(addr[2]), .iRAM_DATA(wd[2]),
    .oRAM_DATA(rd[2]), .oRAM_ACK(ack[2]), .oRAM_ERR(er[2]), .oRAM_BUSY(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; lat counts negedges after the accept edge until ACK (-1 = timeout).
  task automatic access(input int d, input logic w, input logic [1:0] s, input logic u,
                        input logic [9:0] a, input logic [31:0] dat,
                        output int lat, output logic [31:0] q, output logic e,
                        output logic busy_ok);
    @(negedge clk);
    ce[d] = 1'b1; req[d] = 1'b1; wr[d] = w; sz[d] = s; uns[d] = u; addr[d] = a; wd[d] = dat;
    @(posedge clk);
    #1 req[d] = 1'b0;
    lat = -1; q = '0; e = 1'b0; busy_ok = 1'b1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (busy[d] !== 1'b1) busy_ok = 1'b0;
      if (ack[d] === 1'b1) begin
        lat = k; q = rd[d]; e = er[d];
      end
    end
  endtask

  task automatic op(input int d, input logic w, input logic [1:0] s, input logic u,
                    input logic [9:0] a, input logic [31:0] dat, input logic [31:0] exp_load,
                    input logic exp_err, input int exp_lat, input string tag);
    int lat;
    logic [31:0] q, exp_q;
    logic e, bok;
    access(d, w, s, u, a, dat, lat, q, e, bok);
    exp_q = (!w && !exp_err) ? exp_load : last_q[d];
    last_q[d] = exp_q;
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, ".data"}, q, exp_q);
    check({tag, ".busy"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; ce[i] = 1'b0; req[i] = 1'b0; wr[i] = 1'b0; uns[i] = 1'b0;
      sz[i] = 2'b00; addr[i] = '0; wd[i] = '0; last_q[i] = '0;
    end
    @(negedge clk);
    check("rst.data", rd[0], 32'h0);
    check("rst.flags", {29'd0, busy[0], ack[0], er[0]}, 32'h0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Zero-wait word round trip, then byte/half lanes with extension
    op(0, 1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0, 1, "sw10");
    op(0, 0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 1, "lw10");
    @(negedge clk);
    check("ack.pulse", {31'd0, ack[0]}, 32'h0);
    op(0, 1, 2'b00, 0, 10'h011, 32'h0000007F, 32'h0, 0, 1, "sb11");
    op(0, 0, 2'b00, 0, 10'h011, 32'h0, 32'h0000007F, 0, 1, "lb11");
    op(0, 0, 2'b00, 1, 10'h013, 32'h0, 32'h000000DE, 0, 1, "lbu13");
    op(0, 0, 2'b00, 0, 10'h013, 32'h0, 32'hFFFFFFDE, 0, 1, "lb13");
    op(0, 0, 2'b01, 1, 10'h012, 32'h0, 32'h0000DEAD, 0, 1, "lhu12");
    op(0, 0, 2'b01, 0, 10'h012, 32'h0, 32'hFFFFDEAD, 0, 1, "lh12");
    op(0, 0, 2'b01, 0, 10'h010, 32'h0, 32'h00007FEF, 0, 1, "lh10");

    // Errors: misaligned, illegal size, index == DEPTH (128 -> byte 0x200)
    op(0, 1, 2'b10, 0, 10'h000, 32'h5A5A5A5A, 32'h0, 0, 1, "sw00");
    op(0, 0, 2'b10, 0, 10'h012, 32'h0, 32'h0, 1, 0, "lw12err");
    op(0, 0, 2'b01, 0, 10'h011, 32'h0, 32'h0, 1, 0, "lh11err");
    op(0, 1, 2'b11, 0, 10'h010, 32'hFFFFFFFF, 32'h0, 1, 0, "sx10err");
    op(0, 1, 2'b10, 0, 10'h200, 32'hAAAAAAAA, 32'h0, 1, 0, "sw200err");
    op(0, 0, 2'b10, 0, 10'h200, 32'h0, 32'h0, 1, 0, "lw200err");
    op(0, 0, 2'b10, 0, 10'h010, 32'h0, 32'hDEAD7FEF, 0, 1, "lw10post");
    op(0, 0, 2'b10, 0, 10'h000, 32'h0, 32'h5A5A5A5A, 0, 1, "lw00post");
    op(0, 1, 2'b10, 0, 10'h1FC, 32'h0BADCAFE, 32'h0, 0, 1, "sw1fc");
    op(0, 0, 2'b10, 0, 10'h1FC, 32'h0, 32'h0BADCAFE, 0, 1, "lw1fc");

    // Chip enable low: requests ignored
    op(0, 1, 2'b10, 0, 10'h040, 32'h11223344, 32'h0, 0, 1, "sw40");
    @(negedge clk);
    ce[0] = 1'b0; req[0] = 1'b1; wr[0] = 1'b1; sz[0] = 2'b10; addr[0] = 10'h040; wd[0] = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ce0.idle", {30'd0, busy[0], ack[0]}, 32'h0);
    end
    req[0] = 1'b0;
    op(0, 0, 2'b10, 0, 10'h040, 32'h0, 32'h11223344, 0, 1, "lw40");

    // Wait states RD=3 / WR=1, and REQ held high across completion
    op(1, 1, 2'b10, 0, 10'h030, 32'hA5A5A5A5, 32'h0, 0, 2, "w.sw30");
    op(1, 0, 2'b10, 0, 10'h031, 32'h0, 32'h0, 1, 0, "w.lw31err");
    @(negedge clk);
    ce[1] = 1'b1; req[1] = 1'b1; wr[1] = 1'b0; sz[1] = 2'b10; addr[1] = 10'h030;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) lat = k;
    end
    check("w.hold.lat", 32'(lat), 32'd4);
    check("w.hold.data", rd[1], 32'hA5A5A5A5);
    @(negedge clk);
    check("w.hold.idle", {31'd0, busy[1]}, 32'h0);
    @(negedge clk);
    check("w.hold.reacc", {31'd0, busy[1]}, 32'h1);
    req[1] = 1'b0;
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) lat = k + 1;
    end
    check("w.hold.lat2", 32'(lat), 32'd4);

    // Reset in the middle of a long store drops it
    op(2, 1, 2'b10, 0, 10'h020, 32'hCAFEF00D, 32'h0, 0, 5, "r.sw20");
    op(2, 0, 2'b10, 0, 10'h020, 32'h0, 32'hCAFEF00D, 0, 1, "r.lw20");
    @(negedge clk);
    ce[2] = 1'b1; req[2] = 1'b1; wr[2] = 1'b1; sz[2] = 2'b10; addr[2] = 10'h020; wd[2] = 32'h12345678;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst[2] = 1'b1;
    #1;
    check("r.async.data", rd[2], 32'h0);
    check("r.async.flags", {29'd0, busy[2], ack[2], er[2]}, 32'h0);
    @(negedge clk);
    rst[2] = 1'b0;
    last_q[2] = '0;
    op(2, 0, 2'b10, 0, 10'h020, 32'h0, 32'hCAFEF00D, 0, 1, "r.lw20post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
